// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       TXD,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic        stop_q, stop_d;
   logic [7:0]  data_q, data_d;
   logic        txd_q, txd_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? 16'd0 : cnt_q + 16'd1;
      idx_d   = idx_q;
      stop_d  = stop_q;
      data_d  = data_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d  = 16'd0;
            txd_d  = 1'b1;
            busy_d = 1'b0;
            if (tx_start) begin
               data_d  = tx_data;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
               idx_d   = 3'd0;
               stop_d  = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               txd_d   = data_q[0];
               idx_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  txd_d   = ^data_q;
                  state_d = PARITY;
`else
                  txd_d   = 1'b1;
                  stop_d  = 1'b0;
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
                  txd_d = data_q[idx_q + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               txd_d   = 1'b1;
               stop_d  = 1'b0;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               // Landing in IDLE with busy low lets a waiting tx_start go straight out next edge.
               if (stop_q == STOP_LAST) begin
                  txd_d   = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         idx_q   <= 3'd0;
         stop_q  <= 1'b0;
         data_q  <= 8'd0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         data_q  <= data_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign TXD     = txd_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Three transmitter configurations driven in lockstep, each compared every cycle to a frame-position model;
// the 2-stop-bit instance is also looped back into a simple receiver.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int CPB [3] = '{1, 4, 1};
   localparam int SB  [3] = '{1, 1, 2};

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [2:0] txd_w, busy_w, done_w;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   always #5 clk = ~clk;

   uart_transmitter #(.CLKS_PER_BIT(CPB[0]), .STOP_BITS(SB[0])) u_dut0 (
      .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
      .TXD(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
   uart_transmitter #(.CLKS_PER_BIT(CPB[1]), .STOP_BITS(SB[1])) u_dut1 (
      .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
      .TXD(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
   uart_transmitter #(.CLKS_PER_BIT(CPB[2]), .STOP_BITS(SB[2])) u_dut2 (
      .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
      .TXD(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: position within the frame in clk cycles (-1 = idle), latched byte, done flag.
   int         pos   [3] = '{-1, -1, -1};
   logic [7:0] md    [3];
   bit         mdone [3] = '{0, 0, 0};

   function automatic int flen(input int k);
      return CPB[k] * (9 + PAR + SB[k]);
   endfunction

   function automatic logic exp_bit(input int k, input int p);
      int b;
      b = p / CPB[k];
      if (b == 0) return 1'b0;
      if (b <= 8) return md[k][b-1];
      if (PAR == 1 && b == 9) return ^md[k];
      return 1'b1;
   endfunction

   // Loopback receiver on instance 2 (one clk per bit).
   int         rxc = 0;
   logic [7:0] rxb;
   logic [7:0] rx_q [$];

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            pos[k]   = -1;
            mdone[k] = 1'b0;
         end else if (pos[k] < 0) begin
            mdone[k] = 1'b0;
            if (tx_start) begin
               pos[k] = 0;
               md[k]  = tx_data;
            end
         end else begin
            pos[k]++;
            if (pos[k] == flen(k)) begin
               pos[k]   = -1;
               mdone[k] = 1'b1;
               if (k == 2) begin
                  chk("loopback_count", rx_q.size(), 1);
                  if (rx_q.size() > 0) chk("loopback_data", rx_q.pop_front(), md[2]);
               end
            end
         end
      end
      if (!reset) begin
         rxc = 0;
         rx_q.delete();
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("txd%0d", k), txd_w[k], (pos[k] < 0) ? 1'b1 : exp_bit(k, pos[k]));
            chk($sformatf("busy%0d", k), busy_w[k], pos[k] >= 0);
            chk($sformatf("done%0d", k), done_w[k], mdone[k]);
         end
         if (rxc == 0) begin
            if (txd_w[2] == 1'b0) rxc = 1;
         end else if (rxc <= 8) begin
            rxb[rxc-1] = txd_w[2];
            if (rxc == 8) rx_q.push_back(rxb);
            rxc++;
         end else begin
            rxc = (rxc == 8 + PAR + SB[2]) ? 0 : rxc + 1;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = (pos[0] < 0) && (pos[1] < 0) && (pos[2] < 0) && !mdone[0] && !mdone[1] && !mdone[2];
      end
      chk("idle_reached", ok, 1'b1);
   endtask

   initial begin
      reset    = 1'b0;
      tx_start = 1'b1;
      tx_data  = 8'hFF;
      @(posedge clk);
      #1 armed = 1'b1;
      cycles(3);
      reset    = 1'b1;
      tx_start = 1'b0;
      cycles(2);

      // Directed frames: A5, 01, parity cases 07/A5, all-ones.
      send(8'hA5); wait_idle();
      send(8'h01); wait_idle();
      send(8'h07); wait_idle();
      send(8'hFF); wait_idle();

      // tx_start held high, data changed mid-frame: back-to-back frames.
      tx_data  = 8'h3C;
      tx_start = 1'b1;
      cycles(3);
      tx_data  = 8'hC3;
      cycles(25);
      tx_start = 1'b0;
      wait_idle();

      // Reset during data bit 4 of the 1-clk/bit instances.
      send(8'h96);
      cycles(5);
      reset = 1'b0;
      cycles(1);
      reset = 1'b1;
      cycles(2);
      send(8'h5A); wait_idle();

      // Random frames with random gaps, stray starts and data churn mid-frame.
      for (int i = 0; i < 30; i++) begin
         send(8'($urandom));
         for (int g = $urandom_range(0, 45); g > 0; g--) begin
            tx_data  = 8'($urandom);
            tx_start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
         end
         tx_start = 1'b0;
      end
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
